// File: rtl/cache_refill_ctrl.sv
// Blocking read controller for a direct-mapped cache: one-cycle lookup, 4-beat
// block refill from memory on a miss, invalidate-all flush, and hit/miss counters.
module cache_refill_ctrl #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic [11:0]       arr_idx,
  output logic [2:0]        arr_tag,
  input  logic              tag_hit,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              arr_inv,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = 12;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REQ,
    S_FILL,
    S_RESP,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              hit_inc, miss_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      beat_q       <= 2'd0;
      flush_pend_q <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    cpu_valid = 1'b0;
    arr_we    = 1'b0;
    arr_inv   = 1'b0;
    mem_req   = 1'b0;
    arr_wdata = '0;
    arr_idx   = addr_q[IDX_W-1:0];
    arr_tag   = addr_q[ADDR_W-1:IDX_W];

    unique case (state_q)
      S_IDLE: begin
        // A flush (new or pending) takes the cycle; a coincident request is dropped.
        if (flush || flush_pend_q) begin
          state_d = S_FLUSH;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tag_hit) begin
          rdata_d = arr_rdata;
          hit_inc = 1'b1;
          state_d = S_RESP;
        end else begin
          miss_inc = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          beat_d  = 2'd0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        arr_idx = {addr_q[IDX_W-1:2], beat_q};
        if (mem_rvalid) begin
          arr_we    = 1'b1;
          arr_wdata = mem_rdata;
          beat_d    = beat_q + 2'd1;
          if (beat_q == addr_q[1:0]) begin
            rdata_d = mem_rdata;
          end
          if (beat_q == 2'd3) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        cpu_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_FLUSH: begin
        arr_inv = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Flushes that arrive mid-transaction are remembered and replayed from IDLE.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (state_q == S_IDLE && state_d == S_FLUSH) begin
      flush_pend_d = 1'b0;
    end else if (flush && state_q != S_IDLE) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && hit_cnt_q != CNT_MAX) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
    if (miss_inc && miss_cnt_q != CNT_MAX) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // rst is folded in so cpu_ready reads 0 for the whole time reset is held.
  assign cpu_ready = rst && (state_q == S_IDLE) && !flush_pend_q && !flush;
  assign cpu_rdata = rdata_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboarded bench for cache_refill_ctrl; a second instance with 3-bit
// counters shares all inputs so counter saturation is reachable quickly.
module tb_cache_refill_ctrl;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 14;
  localparam int SAT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              flush = 1'b0;
  logic              tag_hit = 1'b0;
  logic [DATA_W-1:0] arr_rdata = '0;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic              cpu_ready, cpu_valid, arr_we, arr_inv, mem_req;
  logic [DATA_W-1:0] cpu_rdata, arr_wdata;
  logic [11:0]       arr_idx;
  logic [2:0]        arr_tag;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;

  logic              s_cpu_ready, s_cpu_valid, s_arr_we, s_arr_inv, s_mem_req;
  logic [DATA_W-1:0] s_cpu_rdata, s_arr_wdata;
  logic [11:0]       s_arr_idx;
  logic [2:0]        s_arr_tag;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [SAT_W-1:0]  s_hit_cnt, s_miss_cnt;

  int tests = 0;
  int fails = 0;
  int hit_exp = 0;
  int miss_exp = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  cache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .flush(flush), .arr_idx(arr_idx), .arr_tag(arr_tag), .tag_hit(tag_hit),
    .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wdata(arr_wdata),
    .arr_inv(arr_inv), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_refill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(s_cpu_ready), .cpu_valid(s_cpu_valid), .cpu_rdata(s_cpu_rdata),
    .flush(flush), .arr_idx(s_arr_idx), .arr_tag(s_arr_tag), .tag_hit(tag_hit),
    .arr_rdata(arr_rdata), .arr_we(s_arr_we), .arr_wdata(s_arr_wdata),
    .arr_inv(s_arr_inv), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic run_read(input logic [ADDR_W-1:0] addr, input bit hit,
                          input logic [DATA_W-1:0] hit_data, input int gnt_wait,
                          input logic [DATA_W-1:0] base, input int gap,
                          input int flush_beat, input string nm);
    logic [DATA_W-1:0] want;
    logic [11:0]       want_idx;
    logic [SAT_W-1:0]  sat_want;
    int waited;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (!cpu_ready && waited < 32);
    tests++;
    if (cpu_ready !== 1'b1) begin fails++; $display("FAIL %s ready_wait: got %b want 1", nm, cpu_ready); end
    cpu_req  = 1'b1;
    cpu_addr = addr;
    exp_q.push_back(hit ? hit_data : base + DATA_W'(addr[1:0]));

    @(negedge clk);
    cpu_req = 1'b0; tag_hit = hit; arr_rdata = hit ? hit_data : 32'hDEAD_BEEF; #1;
    tests++;
    if (arr_idx !== addr[11:0]) begin fails++; $display("FAIL %s lookup_idx: got %h want %h", nm, arr_idx, addr[11:0]); end
    tests++;
    if (arr_tag !== addr[14:12]) begin fails++; $display("FAIL %s lookup_tag: got %h want %h", nm, arr_tag, addr[14:12]); end
    if (hit) hit_exp++; else miss_exp++;

    if (!hit) begin
      for (int g = 0; g <= gnt_wait; g++) begin
        @(negedge clk);
        tag_hit = 1'b0; mem_gnt = (g == gnt_wait); mem_rvalid = (g == 0); mem_rdata = 32'hBAD0_0000; #1;
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL %s mem_req: got %b want 1", nm, mem_req); end
        tests++;
        if (mem_addr !== {addr[14:2], 2'b00}) begin fails++; $display("FAIL %s mem_addr: got %h want %h", nm, mem_addr, {addr[14:2], 2'b00}); end
        tests++;
        if (arr_we !== 1'b0) begin fails++; $display("FAIL %s we_in_req: got %b want 0", nm, arr_we); end
      end
      for (int b = 0; b < 4; b++) begin
        for (int k = 0; k < gap; k++) begin
          @(negedge clk);
          mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = (k == 0 && b == flush_beat); #1;
          tests++;
          if (arr_we !== 1'b0) begin fails++; $display("FAIL %s we_in_gap: got %b want 0", nm, arr_we); end
        end
        @(negedge clk);
        flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = base + DATA_W'(b); #1;
        want_idx = {addr[11:2], 2'(b)};
        tests++;
        if (arr_we !== 1'b1) begin fails++; $display("FAIL %s beat%0d_we: got %b want 1", nm, b, arr_we); end
        tests++;
        if (arr_idx !== want_idx) begin fails++; $display("FAIL %s beat%0d_idx: got %h want %h", nm, b, arr_idx, want_idx); end
        tests++;
        if (arr_tag !== addr[14:12]) begin fails++; $display("FAIL %s beat%0d_tag: got %h want %h", nm, b, arr_tag, addr[14:12]); end
        tests++;
        if (arr_wdata !== base + DATA_W'(b)) begin fails++; $display("FAIL %s beat%0d_wdata: got %h want %h", nm, b, arr_wdata, base + DATA_W'(b)); end
      end
    end

    @(negedge clk);
    tag_hit = 1'b0; mem_rvalid = 1'b0; arr_rdata = '0; #1;
    want = exp_q.pop_front();
    tests++;
    if (cpu_valid !== 1'b1) begin fails++; $display("FAIL %s cpu_valid: got %b want 1", nm, cpu_valid); end
    tests++;
    if (cpu_rdata !== want) begin fails++; $display("FAIL %s cpu_rdata: got %h want %h", nm, cpu_rdata, want); end
    tests++;
    if (hit_cnt !== CNT_W'(hit_exp)) begin fails++; $display("FAIL %s hit_cnt: got %0d want %0d", nm, hit_cnt, hit_exp); end
    tests++;
    if (miss_cnt !== CNT_W'(miss_exp)) begin fails++; $display("FAIL %s miss_cnt: got %0d want %0d", nm, miss_cnt, miss_exp); end
    sat_want = (miss_exp > 7) ? 3'd7 : SAT_W'(miss_exp);
    tests++;
    if (s_miss_cnt !== sat_want) begin fails++; $display("FAIL %s sat_miss_cnt: got %0d want %0d", nm, s_miss_cnt, sat_want); end
    $display("[TB] %s addr=%h hit=%0b data=%h hits=%0d misses=%0d", nm, addr, hit, cpu_rdata, hit_cnt, miss_cnt);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
    tests++;
    if ({cpu_valid, arr_we, arr_inv, mem_req} !== 4'b0) begin fails++; $display("FAIL rst_strobes: got %b want 0000", {cpu_valid, arr_we, arr_inv, mem_req}); end
    tests++;
    if ({hit_cnt, miss_cnt} !== '0) begin fails++; $display("FAIL rst_counters: got %h want 0", {hit_cnt, miss_cnt}); end
    tests++;
    if ({cpu_rdata, mem_addr, arr_idx} !== '0) begin fails++; $display("FAIL rst_data: got %h want 0", {cpu_rdata, mem_addr, arr_idx}); end
    @(negedge clk); @(negedge clk);
    rst = 1'b1; #1;
    tests++;
    if (cpu_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", cpu_ready); end
    $display("[TB] reset released");
  endtask

  task automatic test_miss_fill();
    @(negedge clk); flush = 1'b1; #1;
    tests++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", cpu_ready); end
    @(negedge clk); flush = 1'b0; #1;
    tests++;
    if (arr_inv !== 1'b1) begin fails++; $display("FAIL flush_inv: got %b want 1", arr_inv); end
    $display("[TB] initial flush");
    run_read(15'h0005, 1'b0, '0, 2, 32'h0000_00A0, 0, -1, "miss_0005");
  endtask

  task automatic test_hit();
    run_read(15'h0005, 1'b1, 32'h0000_00A1, 0, '0, 0, -1, "hit_0005");
  endtask

  task automatic test_back_to_back();
    run_read(15'h7FFF, 1'b1, 32'hFEED_0001, 0, '0, 0, -1, "b2b_hit_7fff");
    run_read(15'h4ABC, 1'b0, '0, 0, 32'h1111_0000, 1, -1, "b2b_miss_4abc");
    run_read(15'h4ABD, 1'b1, 32'h1111_0001, 0, '0, 0, -1, "b2b_hit_4abd");
  endtask

  task automatic test_flush_collide();
    int inv_seen;
    @(negedge clk); #1;
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 15'h0123; tag_hit = 1'b1; arr_rdata = 32'h5555_5555; #1;
    tests++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL collide_ready: got %b want 0", cpu_ready); end
    @(negedge clk); flush = 1'b0; cpu_req = 1'b0; #1;
    tests++;
    if (arr_inv !== 1'b1) begin fails++; $display("FAIL collide_inv: got %b want 1", arr_inv); end
    @(negedge clk); #1;
    tests++;
    if (cpu_ready !== 1'b1) begin fails++; $display("FAIL collide_ready_back: got %b want 1", cpu_ready); end
    inv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (cpu_valid === 1'b1 || arr_inv === 1'b1) inv_seen++;
    end
    tests++;
    if (inv_seen !== 0) begin fails++; $display("FAIL collide_no_access: got %0d strobes want 0", inv_seen); end
    tag_hit = 1'b0;
    tests++;
    if (hit_cnt !== CNT_W'(hit_exp)) begin fails++; $display("FAIL collide_hit_cnt: got %0d want %0d", hit_cnt, hit_exp); end
    $display("[TB] flush+req collision, request dropped");
  endtask

  task automatic test_flush_during_fill();
    int inv_count;
    run_read(15'h1236, 1'b0, '0, 1, 32'h0000_00C0, 2, 2, "fill_flush_1236");
    inv_count = 0;
    @(negedge clk); #1;
    tests++;
    if (cpu_ready !== 1'b0) begin fails++; $display("FAIL pend_ready: got %b want 0", cpu_ready); end
    if (arr_inv === 1'b1) inv_count++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (arr_inv === 1'b1) inv_count++;
    end
    tests++;
    if (inv_count !== 1) begin fails++; $display("FAIL pend_inv_count: got %0d want 1", inv_count); end
    tests++;
    if (cpu_ready !== 1'b1) begin fails++; $display("FAIL pend_ready_back: got %b want 1", cpu_ready); end
    $display("[TB] deferred flush issued %0d invalidate", inv_count);
  endtask

  task automatic test_reset_mid_fill();
    int we_seen;
    int waited;
    waited = 0;
    do begin
      @(negedge clk); #1;
      waited++;
    end while (!cpu_ready && waited < 32);
    cpu_req = 1'b1; cpu_addr = 15'h2009;
    @(negedge clk); cpu_req = 1'b0; tag_hit = 1'b0;
    @(negedge clk); mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_00E0;
    @(negedge clk); mem_rdata = 32'h0000_00E1;
    @(negedge clk); mem_rdata = 32'h0000_00E2; rst = 1'b0; #1;
    tests++;
    if ({cpu_ready, cpu_valid, arr_we, arr_inv, mem_req} !== 5'b0) begin fails++; $display("FAIL midrst_strobes: got %b want 00000", {cpu_ready, cpu_valid, arr_we, arr_inv, mem_req}); end
    tests++;
    if ({hit_cnt, miss_cnt} !== '0) begin fails++; $display("FAIL midrst_counters: got %h want 0", {hit_cnt, miss_cnt}); end
    tests++;
    if ({arr_idx, mem_addr, cpu_rdata} !== '0) begin fails++; $display("FAIL midrst_data: got %h want 0", {arr_idx, mem_addr, cpu_rdata}); end
    @(negedge clk);
    @(negedge clk); rst = 1'b1; mem_rdata = 32'h0000_00E3; #1;
    tests++;
    if (cpu_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b want 1", cpu_ready); end
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (arr_we === 1'b1) we_seen++;
    end
    mem_rvalid = 1'b0;
    tests++;
    if (we_seen !== 0) begin fails++; $display("FAIL midrst_no_we: got %0d writes want 0", we_seen); end
    exp_q.delete();
    hit_exp = 0;
    miss_exp = 0;
    $display("[TB] reset during refill, refill abandoned");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      run_read(15'($urandom_range(0, 32767)), 1'b0, '0, 0, 32'h3000_0000 + 32'(i * 16), 0, -1, "sat_miss");
    end
    tests++;
    if (s_miss_cnt !== 3'd7) begin fails++; $display("FAIL sat_hold: got %0d want 7", s_miss_cnt); end
    tests++;
    if (miss_cnt !== CNT_W'(9)) begin fails++; $display("FAIL sat_main_cnt: got %0d want 9", miss_cnt); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_back_to_back();
    test_flush_collide();
    test_flush_during_fill();
    test_reset_mid_fill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
